// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// Combinational full-subtractor: difference and borrow-out of a - b - bin.
module fs_cell (
    input  logic a_in,
    input  logic b_in,
    input  logic bin_in,
    output logic d_out,
    output logic b_out
);

    assign d_out = a_in ^ b_in ^ bin_in;
    assign b_out = (~a_in & b_in) | (~(a_in ^ b_in) & bin_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (LSB first) with valid/ready on both sides.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out,
    output logic             overflow_out
);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic [CNT_W-1:0] cnt;
    logic             borrow_reg;
    logic             cell_d;
    logic             cell_bout;

    fs_cell u_cell (
        .a_in   (a_sh[0]),
        .b_in   (b_sh[0]),
        .bin_in (borrow_reg),
        .d_out  (cell_d),
        .b_out  (cell_bout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            diff_out     <= '0;
            borrow_out   <= 1'b0;
            overflow_out <= 1'b0;
            a_sh         <= '0;
            b_sh         <= '0;
            d_sh         <= '0;
            cnt          <= '0;
            borrow_reg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh       <= a_in;
                        b_sh       <= b_in;
                        d_sh       <= '0;
                        cnt        <= '0;
                        borrow_reg <= 1'b0;
                        in_ready   <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    a_sh       <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh       <= {1'b0, b_sh[WIDTH-1:1]};
                    d_sh       <= {cell_d, d_sh[WIDTH-1:1]};
                    borrow_reg <= cell_bout;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        // Last bit: the operand bits in the cell now are the sign bits.
                        cnt          <= '0;
                        diff_out     <= {cell_d, d_sh[WIDTH-1:1]};
                        borrow_out   <= cell_bout;
                        overflow_out <= (a_sh[0] != b_sh[0]) && (cell_d != a_sh[0]);
                        out_valid    <= 1'b1;
                        state        <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial W-bit subtractor computing diff = a - b, one bit per cycle, LSB first.
- Built around a combinational full-subtractor cell (difference/borrow), which is the inverse of the existing full-adder sum/carry cell.
- Operands arrive on a valid/ready handshake; the result leaves on a second valid/ready handshake.
- Used as the arithmetic back-end for lab datapaths that need subtraction without a W-bit ripple chain.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).
- CNT_W, $clog2(WIDTH), width of the bit counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands (IDLE only)
- a_in  in  WIDTH  minuend
- b_in  in  WIDTH  subtrahend
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  consumer accepts result
- diff_out  out  WIDTH  a - b modulo 2^WIDTH
- borrow_out  out  1  unsigned borrow (a < b)
- overflow_out  out  1  signed two's-complement overflow

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, diff_out=0, borrow_out=0, overflow_out=0, counter=0, borrow register=0.
- Reset mid-operation: the block aborts and is in IDLE after the edge. The partial result is discarded; nothing is emitted.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: load a_in/b_in into shift registers, clear borrow register and counter, go to RUN.
  - in_valid low: stay in IDLE.
- RUN:
  - in_ready=0; in_valid and operand inputs are ignored.
  - Each cycle the cell takes (a_sh[0], b_sh[0], bin=borrow_reg).
  - Cell equations: d = a^b^bin; bout = (~a&b) | (~(a^b)&bin).
  - d shifts into the MSB of the diff shift register; a_sh and b_sh shift right; borrow_reg <= bout; counter++.
  - When counter==WIDTH-1, capture the sign bits first: a_msb=a_sh[0], b_msb=b_sh[0], d_msb=d. Then go to DONE.
- DONE:
  - out_valid=1.
  - diff_out = diff shift register, fully shifted.
  - borrow_out = final borrow_reg.
  - overflow_out = (a_msb != b_msb) && (d_msb != a_msb).
  - Outputs stay stable while out_ready=0.
  - On out_valid&out_ready: go to IDLE and clear out_valid. diff_out, borrow_out and overflow_out keep their last values.
- Latency: operands accepted at edge k → out_valid high after edge k+WIDTH. Throughput: one op per WIDTH+2 cycles minimum (no IDLE bypass).
- Simultaneous events:
  - in_valid asserted during the DONE handshake cycle is not accepted (in_ready=0). It is accepted on the first IDLE cycle.
  - reset overrides all handshakes.
- Wrap-around: diff is modulo 2^WIDTH; borrow_out flags unsigned underflow; the counter never exceeds WIDTH-1.
- Outputs are registered; no combinational path from inputs to out_valid/diff_out.

Decomposition:
- Package serial_sub_pkg:
  - state enum {IDLE, RUN, DONE} with 2-bit encoding;
  - default WIDTH constant.
- Sub-module fs_cell (ports d_out, b_out, a_in, b_in, bin_in): pure combinational full-subtractor. It is instantiated once and verified exhaustively on its own (8 input combinations).

Test Plan:
- Reset: hold reset 2 cycles → in_ready=1, out_valid=0, diff_out=0x00, borrow_out=0, overflow_out=0.
- a=0x05, b=0x03 accepted at edge k → out_valid rises after edge k+8; diff=0x02, borrow=0, overflow=0.
- a=0x03, b=0x05 → diff=0xFE, borrow=1, overflow=0. Then a=0x80, b=0x01 → diff=0x7F, borrow=0, overflow=1.
- Backpressure: a=0x10, b=0x20; hold out_ready=0 for 5 cycles after out_valid → diff=0xF0, borrow=1 stable throughout. In the same run, in_valid with a=0xAA, b=0x55 during RUN is ignored, and in_ready stays 0 until the cycle after the out_ready handshake.
- Reset mid-operation: start a=0x7F, b=0x01; assert reset at RUN counter=3 → IDLE next cycle, out_valid never asserts. Then a=0xFF, b=0xFF → diff=0x00, borrow=0, overflow=0.
- fs_cell exhaustive: all 8 (a,b,bin) combinations → (d,bout) matches the truth table above, e.g. (0,1,1)→(0,1), (1,0,1)→(0,0).
